wrr_arbiter: RTL
================

# wrr_arbiter

Parametrised weighted round-robin arbiter with registered one-hot grant and per-requester credit counting. It is the successor to the next-grant priority-mask stage in the round-robin arbiter. Arbitration, rotating priority pointer and grant hold are combined in one block, and each requester keeps the grant for up to `weight` acknowledged transfers before priority rotates. It sits between N request sources and one shared resource that signals transfer completion with `ack`.

## Interface
Parameters:
- `N`, default 4: number of requesters (≥1).
- `W`, default 3: weight/credit width in bits.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `request`, in, N: per-requester request, level-sensitive.
- `weight`, in, N*W: requester i quantum at bits [i*W +: W]. Value 0 is treated as 1.
- `ack`, in, 1: one transfer completed by the current grant holder. Ignored when `grant_valid`=0.
- `lock`, in, N: present only with `WRR_LOCK_EN`. Holder keeps the grant past credit expiry.
- `grant`, out, N: registered one-hot grant. All zeros when idle.
- `grant_valid`, out, 1: registered. Equals |grant.
- `grant_id`, out, $clog2(N) (min 1): registered index of the holder. Holds its last value when idle.

## Operation
- State: `pointer` (index with highest priority), `credit` (W bits), FSM IDLE/GRANT.
- Selection function: the first i with request[i]=1, searching pointer, pointer+1, … N-1, 0, … with wrap-around. If no requests, no winner.
- IDLE:
  - If any request, register the winner in `grant`/`grant_id`, set `grant_valid`=1, load `credit` = max(weight[winner],1), go to GRANT.
  - Otherwise stay in IDLE.
- GRANT with holder g, release condition R is either:
  - ack=1 and credit=1 (quantum exhausted), or
  - request[g]=0 (holder withdrew).
- If not R: on ack=1, decrement credit. Otherwise hold. `weight` changes during GRANT are ignored.
- If R: pointer ← (g+1) mod N. Select again in the same cycle using the new pointer, applied to request with bit g masked when the release is by withdrawal.
  - Winner exists: load a new grant and credit, stay in GRANT (no bubble).
  - No winner: grant ← 0, `grant_valid` ← 0, go to IDLE.
- Quantum exhaustion with the holder still requesting and no other requester re-grants the same g with a fresh credit.
- Grant is always one-hot or zero. A requester that is never granted waits at most N-1 quanta (no starvation).

## Timing
- Reset values: grant=0, grant_valid=0, grant_id=0, pointer=0, credit=0, state IDLE.
- Latency: request first seen at edge t in IDLE → grant visible after edge t (available cycle t+1).
- Handover: releasing ack sampled at edge t → new holder's grant visible after the same edge t. There is no idle cycle.
- Withdrawal: request[g] sampled low at edge t → grant moves or drops at edge t.
- Simultaneous: ack and request[g]=0 in the same cycle count as a single release with pointer g+1.
- Reset asserted mid-grant clears all state immediately, regardless of clk.

## Configuration
- `WRR_LOCK_EN` defined: adds the `lock` port. While lock[g]=1, ack with credit=1 does not release. Credit saturates at 1 and the grant holds until lock[g]=0 together with a releasing ack, or until withdrawal.
- `WRR_LOCK_EN` undefined: no `lock` port. Release behaviour is exactly as in Operation.

## Test plan
- Reset: assert reset_n=0 mid-grant → grant=0, grant_valid=0, grant_id=0 immediately. After release, request=4'b1000 → grant=4'b1000 and grant_id=3 one cycle later.
- Weights: N=4, W=3, weights {1,2,3,1}, request=4'b1111, ack held high → grant sequence 0,1,1,2,2,2,3,0,… with no idle cycles.
- Wrap-around: pointer at 3, request=4'b0101, holder 3 released → next grant=4'b0001 (index 0 before 2).
- Withdrawal: holder 1 with credit 3, request drops to 4'b0100 → grant=4'b0100 after that edge, credit=weight[2].
- Idle/ignored ack: request=0, ack pulses → grant stays 0 and pointer unchanged. Weight 0 on sole requester → grant held one ack, then regranted.
- Lock (`WRR_LOCK_EN`): lock[0]=1, weight[0]=1, 5 acks with other requests pending → grant stays 4'b0001. Lock dropped, next ack → grant moves to index 1.

Source files
------------

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter with registered one-hot grant and per-holder credit; `WRR_LOCK_EN adds a lock port.
module wrr_arbiter #(
    parameter int N = 4,
    parameter int W = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    request,
    input  logic [N*W-1:0]  weight,
    input  logic            ack,
`ifdef WRR_LOCK_EN
    input  logic [N-1:0]    lock,
`endif
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_id
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] pointer_q, pointer_d, grant_id_q, grant_id_d, win;
    logic [W-1:0]  credit_q, credit_d, win_w;
    logic [N-1:0]  grant_q, grant_d, sel_req;
    logic          grant_valid_q, grant_valid_d, lock_g, withdraw, exhaust, rel, found;
    int            sel_ptr;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pointer_q     <= '0;
            credit_q      <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            pointer_q     <= pointer_d;
            credit_q      <= credit_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end
    always_comb begin
        state_d       = state_q;
        pointer_d     = pointer_q;
        credit_d      = credit_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
`ifdef WRR_LOCK_EN
        lock_g        = lock[grant_id_q];
`else
        lock_g        = 1'b0;
`endif
        withdraw      = (state_q == GRANT) && !request[grant_id_q];
        exhaust       = (state_q == GRANT) && ack && (credit_q == W'(1)) && !lock_g;
        rel           = withdraw || exhaust;
        sel_ptr       = rel ? (int'(grant_id_q) + 1) % N : int'(pointer_q);
        sel_req       = request;
        // a withdrawing holder must not win the re-selection even if its bit glitches back
        if (withdraw) sel_req[grant_id_q] = 1'b0;
        found         = 1'b0;
        win           = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && sel_req[(sel_ptr + k) % N]) begin
                found = 1'b1;
                win   = IW'((sel_ptr + k) % N);
            end
        end
        win_w = weight[win*W +: W];
        if (state_q == IDLE || rel) begin
            if (rel) pointer_d = IW'(sel_ptr);
            if (found) begin
                state_d       = GRANT;
                grant_d       = N'(1) << win;
                grant_valid_d = 1'b1;
                grant_id_d    = win;
                credit_d      = (win_w == '0) ? W'(1) : win_w;
            end else begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
            end
        end else if (ack && credit_q > W'(1)) begin
            credit_d = credit_q - W'(1);
        end
    end
    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
endmodule
